i2c_target_regfile: RTL and testbench

Synthesizable, parametrised I2C target (slave) with a DEPTH-entry byte register file.
- Oversamples SCL/SDA on the system clock and implements the protocol: 7-bit address match, register-pointer byte, burst write/read with pointer auto-increment, repeated START.
- Software-visible snoop outputs feed the UVM scoreboard.
- Sits beside the I2C master in the test6 environment and is the synthesizable target the DUT talks to.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bus_sync.sv | 64 ++++++
 rtl/i2c_target_regfile.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register file.
//   - i2c_state_e : protocol FSM states of the target
//   - SDA_START / SDA_STOP : SDA level left behind by a START / STOP edge (SCL high)
//   - ACK / NACK : SDA level of the acknowledge bit
//   - RW_WRITE / RW_READ : value of the R/W bit in the address byte
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StPtr,
        StAckPtr,
        StWdata,
        StAckWdata,
        StRdata,
        StAckRdata
    } i2c_state_e;

    localparam logic SDA_START = 1'b0;
    localparam logic SDA_STOP  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers and bus event detection.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   scl_i, sda_i    : raw pad inputs
//   sda_o           : synchronized SDA level
//   scl_rise_o      : one-clk pulse on synchronized SCL rising edge
//   scl_fall_o      : one-clk pulse on synchronized SCL falling edge
//   start_o, stop_o : one-clk pulse on START / STOP (SDA edge while SCL high)
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    import i2c_pkg::*;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus is high; resetting to 1 avoids phantom edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    always_comb begin
        sda_o      = sda_s;
        scl_rise_o = scl_s & ~scl_prev_q;
        scl_fall_o = ~scl_s & scl_prev_q;
        // SCL must be high on both samples so an SDA change at an SCL edge is not a condition.
        start_o    = scl_s & scl_prev_q & (sda_s != sda_prev_q) & (sda_s == SDA_START);
        stop_o     = scl_s & scl_prev_q & (sda_s != sda_prev_q) & (sda_s == SDA_STOP);
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a DEPTH-entry byte register file.
// Protocol: address byte, register-pointer byte, then burst write; or after a
// (repeated) START with R/W=1, burst read from the pointer. Pointer auto-increments
// and wraps modulo DEPTH.
// Ports:
//   clk, rst_n          : system clock (>=8x SCL), asynchronous active-low reset
//   scl_i, sda_i        : pad inputs
//   sda_oe              : 1 = pull SDA low
//   busy                : addressed and in a transfer
//   wr_strobe/addr/data : one pulse per byte written to the register file
//   rd_strobe/rd_data   : one pulse per byte loaded for transmission
//   ptr                 : current register pointer
module i2c_target_regfile #(
    parameter logic [6:0]  I2C_ADR     = 7'h10,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_strobe,
    output logic [7:0]    rd_data,
    output logic [PW-1:0] ptr
);
    import i2c_pkg::*;

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    i2c_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;       // bits shifted in / driven out in the current byte
    logic [7:0]    sr_q, sr_d;         // receive shift register
    logic [7:0]    tx_q, tx_d;         // transmit shift register, MSB is next bit out
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rd_strobe_q, rd_strobe_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] ptr_inc;
    logic          mem_we;
    logic [7:0]    mem_q [DEPTH];

    assign ptr_inc = ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_strobe_d = 1'b0;
        rd_data_d   = rd_data_q;
        mem_we      = 1'b0;

        if (start) begin
            state_d  = StAddr;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {StAddr, StPtr, StWdata})) begin
                sr_d  = {sr_q[6:0], sda_s};
                cnt_d = cnt_q + 4'd1;
            end
            case (state_q)
                StAddr: begin
                    if (scl_fall && cnt_q == 4'd8) begin
                        if (sr_q[7:1] == I2C_ADR) begin
                            sda_oe_d = 1'b1;
                            rw_d     = sr_q[0];
                            busy_d   = 1'b1;
                            state_d  = StAckAddr;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StAckAddr: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        case (rw_q)
                            RW_WRITE: begin
                                cnt_d   = '0;
                                state_d = StPtr;
                            end
                            RW_READ: begin
                                // Bit 7 goes out on this same fall, so preload the shifted byte.
                                rd_strobe_d = 1'b1;
                                rd_data_d   = mem_q[ptr_q];
                                tx_d        = {mem_q[ptr_q][6:0], 1'b0};
                                sda_oe_d    = ~mem_q[ptr_q][7];
                                cnt_d       = 4'd1;
                                state_d     = StRdata;
                            end
                            default: ;
                        endcase
                    end
                end
                StPtr: begin
                    if (scl_fall && cnt_q == 4'd8) begin
                        if ({24'd0, sr_q} < DEPTH) begin
                            sda_oe_d = 1'b1;
                            ptr_d    = sr_q[PW-1:0];
                            state_d  = StAckPtr;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end
                StAckPtr, StAckWdata: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = StWdata;
                    end
                end
                StWdata: begin
                    if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d    = 1'b1;
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = sr_q;
                        ptr_d       = ptr_inc;
                        state_d     = StAckWdata;
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = StAckRdata;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                StAckRdata: begin
                    if (scl_rise) begin
                        // Pointer moves past the byte just sent, acked or not.
                        ptr_d = ptr_inc;
                        case (sda_s)
                            ACK: begin
                                rd_strobe_d = 1'b1;
                                rd_data_d   = mem_q[ptr_inc];
                                tx_d        = mem_q[ptr_inc];
                                cnt_d       = '0;
                                state_d     = StRdata;
                            end
                            NACK: begin
                                busy_d  = 1'b0;
                                state_d = StIdle;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sr_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            rd_data_q   <= '0;
            ptr_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_strobe_q <= rd_strobe_d;
            rd_data_q   <= rd_data_d;
            ptr_q       <= ptr_d;
            if (mem_we) mem_q[ptr_q] <= sr_q;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_strobe = rd_strobe_q;
    assign rd_data   = rd_data_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: table of write transactions plus
// hand-written read and reset-mid-read sequences.
module tb_i2c_target_regfile;

    localparam int Q = 10;  // clocks per SCL quarter period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe, rd_strobe;
    logic [3:0] wr_addr, ptr;
    logic [7:0] wr_data, rd_data;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_strobe(rd_strobe),
        .rd_data  (rd_data),
        .ptr      (ptr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int oe_cnt   = 0;
    logic [3:0] last_wa = '0;
    logic [7:0] last_wd = '0;

    always @(posedge clk) begin
        if (wr_strobe) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= wr_addr;
            last_wd <= wr_data;
        end
        if (rd_strobe) rd_cnt <= rd_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; wq(Q);
        scl = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq(Q);
        scl = 1'b1; wq(2 * Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq(Q);
        scl = 1'b1; wq(Q);
        b = sda_line; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    typedef struct {
        logic [7:0]       adr_byte;
        logic [7:0]       reg_ptr;
        int               nbytes;
        logic [2:0][7:0]  data;
        logic             exp_adr_nack;
        logic             exp_ptr_nack;
        logic [3:0]       exp_ptr;
        int               exp_wr;
    } wvec_t;

    wvec_t      vec [4];
    logic [7:0] exp_mem [16];

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         wr0, rd0, oe0, nz;

        vec[0] = '{8'h20, 8'h03, 2, {8'h00, 8'h5A, 8'hA5}, 1'b0, 1'b0, 4'd5, 2};
        vec[1] = '{8'h40, 8'h03, 1, {8'h00, 8'h00, 8'hFF}, 1'b1, 1'b1, 4'd5, 0};
        vec[2] = '{8'h20, 8'h10, 1, {8'h00, 8'h00, 8'h77}, 1'b0, 1'b1, 4'd5, 0};
        vec[3] = '{8'h20, 8'h0F, 3, {8'h33, 8'h22, 8'h11}, 1'b0, 1'b0, 4'd2, 3};
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Reset state
        wq(5);
        check("reset sda_oe", 32'(sda_oe), 0);
        check("reset busy", 32'(busy), 0);
        check("reset wr_strobe", 32'(wr_strobe), 0);
        check("reset rd_strobe", 32'(rd_strobe), 0);
        check("reset ptr", 32'(ptr), 0);
        check("reset wr_data", 32'(wr_data), 0);
        check("reset rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        wq(Q);

        // Table of write transactions
        for (int r = 0; r < 4; r++) begin
            wr0 = wr_cnt;
            oe0 = oe_cnt;
            i2c_start();
            write_byte(vec[r].adr_byte, ack);
            check($sformatf("row%0d adr ack", r), 32'(ack), 32'(vec[r].exp_adr_nack));
            check($sformatf("row%0d busy after adr", r), 32'(busy), 32'(!vec[r].exp_adr_nack));
            if (!ack) begin
                write_byte(vec[r].reg_ptr, ack);
                check($sformatf("row%0d ptr ack", r), 32'(ack), 32'(vec[r].exp_ptr_nack));
                if (!ack) begin
                    for (int k = 0; k < vec[r].nbytes; k++) begin
                        write_byte(vec[r].data[k], ack);
                        check($sformatf("row%0d data%0d ack", r, k), 32'(ack), 0);
                        exp_mem[(int'(vec[r].reg_ptr) + k) % 16] = vec[r].data[k];
                    end
                end
            end
            i2c_stop();
            wq(Q);
            check($sformatf("row%0d busy after P", r), 32'(busy), 0);
            check($sformatf("row%0d ptr", r), 32'(ptr), 32'(vec[r].exp_ptr));
            check($sformatf("row%0d wr strobes", r), 32'(wr_cnt - wr0), 32'(vec[r].exp_wr));
            if (vec[r].exp_adr_nack)
                check($sformatf("row%0d sda_oe cycles", r), 32'(oe_cnt - oe0), 0);
        end
        check("last wr_addr", 32'(last_wa), 32'h1);
        check("last wr_data", 32'(last_wd), 32'h33);
        for (int i = 0; i < 16; i++)
            check($sformatf("mem[%0d]", i), 32'(dut.mem_q[i]), 32'(exp_mem[i]));

        // Combined read: pointer 3, two bytes, ACK then NACK
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'h20, ack);
        check("rd adr ack", 32'(ack), 0);
        write_byte(8'h03, ack);
        check("rd ptr ack", 32'(ack), 0);
        i2c_rep_start();
        write_byte(8'h21, ack);
        check("rd adr21 ack", 32'(ack), 0);
        check("rd busy", 32'(busy), 1);
        read_byte(rb, 1'b0);
        check("rd byte0", 32'(rb), 32'hA5);
        read_byte(rb, 1'b1);
        check("rd byte1", 32'(rb), 32'h5A);
        i2c_stop();
        wq(Q);
        check("rd strobes", 32'(rd_cnt - rd0), 2);
        check("rd last rd_data", 32'(rd_data), 32'h5A);
        check("rd ptr", 32'(ptr), 5);
        check("rd busy after P", 32'(busy), 0);

        // Reset during the 4th data bit of a read (A5: 4th bit is 0, target pulls low)
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h03, ack);
        i2c_rep_start();
        write_byte(8'h21, ack);
        for (int i = 0; i < 3; i++) read_bit(ack);
        sda_m = 1'b1; wq(Q);
        scl = 1'b1; wq(Q);
        check("mid-read sda_oe before reset", 32'(sda_oe), 1);
        rst_n = 1'b0;
        #1;
        check("reset sda_oe immediate", 32'(sda_oe), 0);
        check("reset ptr mid-read", 32'(ptr), 0);
        check("reset busy mid-read", 32'(busy), 0);
        nz = 0;
        for (int i = 0; i < 16; i++) if (dut.mem_q[i] != 8'h00) nz++;
        check("reset mem nonzero entries", 32'(nz), 0);
        wq(Q);
        rst_n = 1'b1;
        wq(Q);
        i2c_start();
        write_byte(8'h20, ack);
        check("post-reset adr ack", 32'(ack), 0);
        check("post-reset busy", 32'(busy), 1);
        i2c_stop();
        wq(Q);
        check("post-reset busy after P", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
